// File: rtl/aes_pkg.sv
// Shared AES constants and types for the decryption datapath blocks.
package aes_pkg;

  localparam int unsigned AES_BLOCK_BITS  = 128;
  localparam int unsigned AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } inv_sub_state_t;

  // Lane count must divide the 16-byte state into power-of-two steps.
  function automatic bit lanes_legal(input int unsigned lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module aes_inv_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] InvSbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign data_o = InvSbox[data_i];

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Sequenced InvSubBytes: LANES shared inverse S-boxes walk the 16-byte state
// over 16/LANES cycles, with valid/ready handshakes on both sides.
module aes_inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      In_valid,
  output logic                      In_ready,
  input  logic [AES_BLOCK_BITS-1:0] In_data,
  output logic                      Out_valid,
  input  logic                      Out_ready,
  output logic [AES_BLOCK_BITS-1:0] Out_data,
  output logic                      Busy
);

  localparam int unsigned Steps = AES_BLOCK_BYTES / LANES;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Steps - 1);

  if (!lanes_legal(LANES)) begin : gen_lanes_illegal
    $error("aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  inv_sub_state_t            state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [AES_BLOCK_BITS-1:0] src_q, src_d;
  logic [AES_BLOCK_BITS-1:0] res_q, res_d;
  logic [7:0]                lane_in  [LANES];
  logic [7:0]                lane_out [LANES];

  // Byte 0 is the MSB; returns the top bit index of byte (cnt*LANES+lane).
  function automatic int unsigned byte_msb(input logic [CntW-1:0] cnt, input int unsigned lane);
    return AES_BLOCK_BITS - 1 - 8 * (32'(cnt) * LANES + lane);
  endfunction

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = src_q[byte_msb(cnt_q, l) -: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : gen_lane
    aes_inv_sbox u_sbox (
      .data_i(lane_in[l]),
      .data_o(lane_out[l])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (In_valid) begin
          src_d   = In_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          res_d[byte_msb(cnt_q, l) -: 8] = lane_out[l];
        end
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (Out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  // All outputs are decoded from registers only.
  assign In_ready  = (state_q == IDLE);
  assign Out_valid = (state_q == DONE);
  assign Busy      = (state_q != IDLE);
  assign Out_data  = res_q;

endmodule
